// File: rtl/mc_eject_unit.sv
`timescale 1ns/1ps
// Multicast ejection unit: ejects the local copy of a flit to the core and
// re-injects the residual destination list. Optional statistics: MC_EJECT_STATS_EN.
module mc_eject_unit #(
  parameter int FLIT_WIDTH     = 64,
  parameter int DST_LIST_WIDTH = 25,
  parameter int LOCAL_BIT      = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FLIT_WIDTH-1:0]     in_flit,
  input  logic [DST_LIST_WIDTH-1:0] in_dst_list,
  output logic                      ej_valid,
  input  logic                      ej_ready,
  output logic [FLIT_WIDTH-1:0]     ej_flit,
  output logic                      reinj_valid,
  input  logic                      reinj_ready,
  output logic [FLIT_WIDTH-1:0]     reinj_flit,
  output logic [DST_LIST_WIDTH-1:0] reinj_dst_list,
  output logic                      misroute_err
`ifdef MC_EJECT_STATS_EN
  ,
  output logic [15:0]               stat_ej_cnt,
  output logic [15:0]               stat_reinj_cnt,
  output logic [15:0]               stat_err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [DST_LIST_WIDTH-1:0] LOCAL_MASK =
    {{(DST_LIST_WIDTH-1){1'b0}}, 1'b1} << LOCAL_BIT;

  logic [FLIT_WIDTH-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [AW:0]               r_count;
  logic                      r_reinj_valid;
  logic [FLIT_WIDTH-1:0]     r_reinj_flit;
  logic [DST_LIST_WIDTH-1:0] r_reinj_dst;
  logic                      r_misroute;

  logic                      w_accept;
  logic                      w_loc;
  logic [DST_LIST_WIDTH-1:0] w_res;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_reinj_hs;

  // All three interfaces use valid/ready: a transfer happens on a rising edge
  // where both are high; a producer holds valid and data stable until then.
  // in_ready depends only on registered state, so nothing loops through it.
  assign in_ready   = (r_count != DEPTH_C) && !r_reinj_valid;
  assign w_accept   = in_valid && in_ready;
  assign w_loc      = in_dst_list[LOCAL_BIT];
  assign w_res      = in_dst_list & ~LOCAL_MASK;
  assign w_push     = w_accept && w_loc;
  assign w_pop      = (r_count != '0) && ej_ready;
  assign w_reinj_hs = r_reinj_valid && reinj_ready;

  assign ej_valid       = (r_count != '0);
  assign ej_flit        = r_mem[r_rd_ptr];
  assign reinj_valid    = r_reinj_valid;
  assign reinj_flit     = r_reinj_flit;
  assign reinj_dst_list = r_reinj_dst;
  assign misroute_err   = r_misroute;

  // Storage array carries no reset; its contents are only visible via a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Accept and handshake never coincide: in_ready is low while a replica is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reinj_valid <= 1'b0;
      r_reinj_flit  <= '0;
      r_reinj_dst   <= '0;
      r_misroute    <= 1'b0;
    end else begin
      r_misroute <= w_accept && !w_loc;
      if (w_accept && (w_res != '0)) begin
        r_reinj_valid <= 1'b1;
        r_reinj_flit  <= in_flit;
        r_reinj_dst   <= w_res;
      end else if (w_reinj_hs) begin
        r_reinj_valid <= 1'b0;
      end
    end
  end

`ifdef MC_EJECT_STATS_EN
  logic [15:0] r_stat_ej;
  logic [15:0] r_stat_reinj;
  logic [15:0] r_stat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ej    <= '0;
      r_stat_reinj <= '0;
      r_stat_err   <= '0;
    end else begin
      if (w_push && (r_stat_ej != 16'hFFFF))        r_stat_ej    <= r_stat_ej + 16'd1;
      if (w_reinj_hs && (r_stat_reinj != 16'hFFFF)) r_stat_reinj <= r_stat_reinj + 16'd1;
      if (w_accept && !w_loc && (r_stat_err != 16'hFFFF))
        r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign stat_ej_cnt    = r_stat_ej;
  assign stat_reinj_cnt = r_stat_reinj;
  assign stat_err_cnt   = r_stat_err;
`endif

endmodule

// File: tb/tb_mc_eject_unit.sv
`timescale 1ns/1ps
// Self-checking bench for mc_eject_unit: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_mc_eject_unit;

  localparam int FW = 64;
  localparam int DW = 25;
  localparam int LB = 0;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_flit = '0;
  logic [DW-1:0] in_dst_list = '0;
  logic          ej_valid;
  logic          ej_ready = 1'b0;
  logic [FW-1:0] ej_flit;
  logic          reinj_valid;
  logic          reinj_ready = 1'b0;
  logic [FW-1:0] reinj_flit;
  logic [DW-1:0] reinj_dst_list;
  logic          misroute_err;
`ifdef MC_EJECT_STATS_EN
  logic [15:0]   stat_ej_cnt;
  logic [15:0]   stat_reinj_cnt;
  logic [15:0]   stat_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q[$];

  mc_eject_unit #(
    .FLIT_WIDTH(FW), .DST_LIST_WIDTH(DW), .LOCAL_BIT(LB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit), .in_dst_list(in_dst_list),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_flit(ej_flit),
    .reinj_valid(reinj_valid), .reinj_ready(reinj_ready), .reinj_flit(reinj_flit),
    .reinj_dst_list(reinj_dst_list), .misroute_err(misroute_err)
`ifdef MC_EJECT_STATS_EN
    , .stat_ej_cnt(stat_ej_cnt), .stat_reinj_cnt(stat_reinj_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid    = 1'b0;
    in_flit     = '0;
    in_dst_list = '0;
  endtask

  task automatic drive_flit(input logic [FW-1:0] f, input logic [DW-1:0] d);
    in_valid    = 1'b1;
    in_flit     = f;
    in_dst_list = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL rst_ej_valid got %0h exp 0", ej_valid); end
    checks++; if (reinj_valid !== 1'b0) begin errors++; $display("FAIL rst_reinj_valid got %0h exp 0", reinj_valid); end
    checks++; if (misroute_err !== 1'b0) begin errors++; $display("FAIL rst_misroute got %0h exp 0", misroute_err); end
    checks++; if (reinj_flit !== '0) begin errors++; $display("FAIL rst_reinj_flit got %0h exp 0", reinj_flit); end
    checks++; if (reinj_dst_list !== '0) begin errors++; $display("FAIL rst_reinj_dst got %0h exp 0", reinj_dst_list); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unicast();
    @(negedge clk);
    ej_ready = 1'b1;
    reinj_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL uni_in_ready got %0h exp 1", in_ready); end
    drive_flit(64'hA5, 25'h0000001);
    @(negedge clk);
    drive_idle();
    checks++; if (ej_valid !== 1'b1) begin errors++; $display("FAIL uni_ej_valid got %0h exp 1", ej_valid); end
    checks++; if (ej_flit !== 64'hA5) begin errors++; $display("FAIL uni_ej_flit got %0h exp a5", ej_flit); end
    checks++; if (reinj_valid !== 1'b0) begin errors++; $display("FAIL uni_reinj_valid got %0h exp 0", reinj_valid); end
    checks++; if (misroute_err !== 1'b0) begin errors++; $display("FAIL uni_misroute got %0h exp 0", misroute_err); end
    @(negedge clk);
    checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL uni_drained got %0h exp 0", ej_valid); end
  endtask

  task automatic test_multicast_fork();
    ej_ready = 1'b0;
    reinj_ready = 1'b0;
    drive_flit(64'h1234_5678_9ABC_DEF0, 25'h0000013);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_idle();
      checks++; if (ej_valid !== 1'b1 || ej_flit !== 64'h1234_5678_9ABC_DEF0) begin
        errors++; $display("FAIL mc_ej cyc%0d got v=%0h f=%0h exp v=1 f=123456789abcdef0", c, ej_valid, ej_flit); end
      checks++; if (reinj_valid !== 1'b1 || reinj_dst_list !== 25'h0000012) begin
        errors++; $display("FAIL mc_reinj_hold cyc%0d got v=%0h d=%0h exp v=1 d=12", c, reinj_valid, reinj_dst_list); end
      checks++; if (reinj_flit !== 64'h1234_5678_9ABC_DEF0) begin
        errors++; $display("FAIL mc_reinj_flit cyc%0d got %0h exp 123456789abcdef0", c, reinj_flit); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mc_in_ready_low cyc%0d got %0h exp 0", c, in_ready); end
    end
    reinj_ready = 1'b1;
    @(negedge clk);
    reinj_ready = 1'b0;
    checks++; if (reinj_valid !== 1'b0) begin errors++; $display("FAIL mc_released got %0h exp 0", reinj_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mc_in_ready_back got %0h exp 1", in_ready); end
    ej_ready = 1'b1;
    @(negedge clk);
    checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL mc_drained got %0h exp 0", ej_valid); end
  endtask

  task automatic test_misroute();
    reinj_ready = 1'b0;
    drive_flit(64'h77, 25'h0000100);
    @(negedge clk);
    drive_idle();
    reinj_ready = 1'b1;
    checks++; if (misroute_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %0h exp 1", misroute_err); end
    checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL mis_no_ej got %0h exp 0", ej_valid); end
    checks++; if (reinj_valid !== 1'b1 || reinj_dst_list !== 25'h0000100) begin
      errors++; $display("FAIL mis_reinj got v=%0h d=%0h exp v=1 d=100", reinj_valid, reinj_dst_list); end
    @(negedge clk);
    reinj_ready = 1'b0;
    checks++; if (misroute_err !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %0h exp 0", misroute_err); end
    checks++; if (reinj_valid !== 1'b0) begin errors++; $display("FAIL mis_reinj_done got %0h exp 0", reinj_valid); end
    drive_flit(64'h88, 25'h0);
    @(negedge clk);
    drive_idle();
    checks++; if (misroute_err !== 1'b1 || ej_valid !== 1'b0 || reinj_valid !== 1'b0) begin
      errors++; $display("FAIL empty_list got m=%0h e=%0h r=%0h exp m=1 e=0 r=0", misroute_err, ej_valid, reinj_valid); end
    @(negedge clk);
    checks++; if (misroute_err !== 1'b0) begin errors++; $display("FAIL empty_list_end got %0h exp 0", misroute_err); end
  endtask

  task automatic test_fifo_full_wrap();
    logic [FW-1:0] got_q[$];
    int nxt;
    ej_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d got %0h exp 1", i, in_ready); end
      drive_flit(FW'(i), 25'h1);
      @(negedge clk);
    end
    drive_idle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0h exp 0", in_ready); end
    ej_ready = 1'b1;
    nxt = 5;
    for (int cyc = 0; cyc < 200 && got_q.size() < 10; cyc++) begin
      if (ej_valid) got_q.push_back(ej_flit);
      if (nxt <= 10) begin
        drive_flit(FW'(nxt), 25'h1);
        if (in_ready) nxt++;
      end else drive_idle();
      @(negedge clk);
    end
    drive_idle();
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL wrap_count got %0d exp 10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      checks++; if (got_q[i] !== FW'(i + 1)) begin errors++; $display("FAIL wrap_order%0d got %0h exp %0h", i, got_q[i], i + 1); end
    end
    @(negedge clk);
    checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got %0h exp 0", ej_valid); end
  endtask

  task automatic test_reset_mid();
    ej_ready = 1'b0;
    reinj_ready = 1'b0;
    drive_flit(64'h11, 25'h1);
    @(negedge clk);
    drive_flit(64'h22, 25'h3);
    @(negedge clk);
    drive_idle();
    checks++; if (ej_valid !== 1'b1 || reinj_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup got e=%0h r=%0h exp e=1 r=1", ej_valid, reinj_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ej_valid !== 1'b0 || reinj_valid !== 1'b0 || misroute_err !== 1'b0) begin
      errors++; $display("FAIL mid_async got e=%0h r=%0h m=%0h exp 0 0 0", ej_valid, reinj_valid, misroute_err); end
    checks++; if (reinj_dst_list !== '0) begin errors++; $display("FAIL mid_dst got %0h exp 0", reinj_dst_list); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || ej_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after got rdy=%0h e=%0h exp rdy=1 e=0", in_ready, ej_valid); end
  endtask

`ifdef MC_EJECT_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ej_ready = 1'b1;
    reinj_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_flit(FW'(i), 25'h3);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
    end
    drive_flit(64'h99, 25'h4);
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
    checks++; if (stat_ej_cnt !== 16'd3) begin errors++; $display("FAIL stat_ej got %0d exp 3", stat_ej_cnt); end
    checks++; if (stat_reinj_cnt !== 16'd4) begin errors++; $display("FAIL stat_reinj got %0d exp 4", stat_reinj_cnt); end
    checks++; if (stat_err_cnt !== 16'd1) begin errors++; $display("FAIL stat_err got %0d exp 1", stat_err_cnt); end
  endtask
`endif

  // Reference model: exp_q is the core-bound queue, m_rv/m_rf/m_rd the pending replica.
  task automatic test_random();
    logic          m_rv = 1'b0;
    logic [FW-1:0] m_rf = '0;
    logic [DW-1:0] m_rd = '0;
    logic          m_err = 1'b0;
    logic          m_ready;
    logic          acc;
    logic [DW-1:0] res;
    logic [DW-1:0] d;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      m_ready = (exp_q.size() < DEPTH) && !m_rv;
      checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL rnd_in_ready c%0d got %0h exp %0h", cyc, in_ready, m_ready); end
      checks++; if (ej_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_ej_valid c%0d got %0h exp %0h", cyc, ej_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if (ej_flit !== exp_q[0]) begin errors++; $display("FAIL rnd_ej_flit c%0d got %0h exp %0h", cyc, ej_flit, exp_q[0]); end
      end
      checks++; if (reinj_valid !== m_rv) begin errors++; $display("FAIL rnd_reinj_valid c%0d got %0h exp %0h", cyc, reinj_valid, m_rv); end
      if (m_rv) begin
        checks++; if (reinj_flit !== m_rf || reinj_dst_list !== m_rd) begin
          errors++; $display("FAIL rnd_reinj_data c%0d got %0h/%0h exp %0h/%0h", cyc, reinj_flit, reinj_dst_list, m_rf, m_rd); end
      end
      checks++; if (misroute_err !== m_err) begin errors++; $display("FAIL rnd_misroute c%0d got %0h exp %0h", cyc, misroute_err, m_err); end

      d = DW'($urandom());
      case ($urandom_range(0, 3))
        0: d = DW'(1) << LB;
        1: d = d | (DW'(1) << LB);
        2: d = d & ~(DW'(1) << LB);
        default: d = '0;
      endcase
      in_valid    = ($urandom_range(0, 3) != 0);
      in_flit     = {$urandom(), $urandom()};
      in_dst_list = d;
      ej_ready    = ($urandom_range(0, 2) != 0);
      reinj_ready = ($urandom_range(0, 1) != 0);

      acc = in_valid && m_ready;
      res = d & ~(DW'(1) << LB);
      if (exp_q.size() != 0 && ej_ready) void'(exp_q.pop_front());
      if (acc && d[LB]) exp_q.push_back(in_flit);
      if (m_rv && reinj_ready) m_rv = 1'b0;
      if (acc && res != '0) begin
        m_rv = 1'b1; m_rf = in_flit; m_rd = res;
      end
      m_err = acc && !d[LB];
      @(negedge clk);
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unicast();
    test_multicast_fork();
    test_misroute();
    test_fifo_full_wrap();
    test_reset_mid();
`ifdef MC_EJECT_STATS_EN
    test_stats();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
